fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `fifo` instance among `NUM_REQ` producers. Each producer presents a word with a request. The arbiter picks one producer per cycle, drives the FIFO's `shift_in`/`data_in`, and returns a one-hot grant. A granted producer may hold ownership for up to `MAX_BURST` consecutive words before ownership rotates. It sits directly in front of the FIFO write port; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are combinational; an owner may keep the port for up to MAX_BURST words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic                       fifo_full,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       fifo_shift_in,
  output logic [WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_r, state_n;
  logic [OW-1:0] owner_r, owner_n;
  logic [CW-1:0] burst_cnt_r, burst_cnt_n;

  logic          rr_found;
  logic [OW-1:0] rr_idx;
  logic [OW-1:0] rr_cand;
  int            rr_pos;

  logic          grant_vld;
  logic [OW-1:0] grant_idx;

  // State register: the only sequential process
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r     <= IDLE;
      owner_r     <= OW'(NUM_REQ - 1);
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_n;
      owner_r     <= owner_n;
      burst_cnt_r <= burst_cnt_n;
    end
  end

  // Round-robin search starting just after the current owner; owner is checked last
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = 0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_pos  = (int'(owner_r) + k) % NUM_REQ;
      rr_cand = OW'(rr_pos);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // Next-state and grant decision; a full FIFO freezes everything
  always_comb begin
    state_n     = state_r;
    owner_n     = owner_r;
    burst_cnt_n = burst_cnt_r;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    if (!res && !fifo_full) begin
      case (state_r)
        IDLE: begin
          if (rr_found) begin
            grant_vld   = 1'b1;
            grant_idx   = rr_idx;
            owner_n     = rr_idx;
            burst_cnt_n = CW'(1);
            state_n     = (MAX_BURST > 1) ? BURST : IDLE;
          end else begin
            state_n = IDLE;
          end
        end
        BURST: begin
          if (req[owner_r] && (burst_cnt_r < CW'(MAX_BURST))) begin
            grant_vld   = 1'b1;
            grant_idx   = owner_r;
            burst_cnt_n = burst_cnt_r + CW'(1);
          end else if (rr_found) begin
            // Handover in the same cycle; an exhausted lone owner wins itself again
            grant_vld   = 1'b1;
            grant_idx   = rr_idx;
            owner_n     = rr_idx;
            burst_cnt_n = CW'(1);
          end else begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n     = IDLE;
          burst_cnt_n = '0;
        end
      endcase
    end else begin
      grant_vld = 1'b0;
    end
  end

  // Output decode: one-hot grant and data mux of the granted slice
  always_comb begin
    grant        = '0;
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && (grant_idx == OW'(i))) begin
        grant[i]     = 1'b1;
        fifo_data_in = req_data[i*WIDTH +: WIDTH];
      end else begin
        grant[i] = 1'b0;
      end
    end
    fifo_shift_in = grant_vld;
  end

  assign owner = owner_r;
  assign busy  = (state_r == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by random
// traffic, compared each cycle against a behavioural round-robin/burst model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 2;
  localparam int OW = 2;

  logic           clk = 1'b0;
  logic           res;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           fifo_full;
  logic [N-1:0]   grant;
  logic           fifo_shift_in;
  logic [W-1:0]   fifo_data_in;
  logic [OW-1:0]  owner;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .res(res), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .grant(grant), .fifo_shift_in(fifo_shift_in), .fifo_data_in(fifo_data_in),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int           m_owner;
  int           m_used;
  bit           m_busy;
  int           cur_w;
  bit           d_shift;
  logic [W-1:0] d_data;
  bit           pop_en;
  logic [W-1:0] last_pop;
  logic [W-1:0] fifo_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int i);
    return req_data[i*W +: W];
  endfunction

  // who should own the write port this cycle (-1 = nobody)
  function automatic int exp_winner();
    int idx;
    if (res || fifo_full) return -1;
    if (m_busy && req[OW'(m_owner)] && m_used < MB) return m_owner;
    for (int k = 1; k <= N; k++) begin
      idx = (m_owner + k) % N;
      if (req[OW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = N - 1;
    m_used  = 0;
    m_busy  = 1'b0;
  endtask

  task automatic sample();
    logic [N-1:0] eg;
    @(negedge clk);
    cur_w = exp_winner();
    eg = '0;
    if (cur_w >= 0) eg[OW'(cur_w)] = 1'b1;
    check("grant", 64'(grant), 64'(eg));
    check("shift_in", 64'(fifo_shift_in), 64'(cur_w >= 0));
    check("data_in", 64'(fifo_data_in), (cur_w >= 0) ? 64'(slice(cur_w)) : 64'd0);
    check("owner", 64'(owner), 64'(m_owner));
    check("busy", 64'(busy), 64'(m_busy));
    check("burst_cnt", 64'(dut.burst_cnt_r), 64'(m_used));
    d_shift = fifo_shift_in;
    d_data  = fifo_data_in;
  endtask

  task automatic adv();
    @(posedge clk);
    if (cur_w >= 0) begin
      if (m_busy && cur_w == m_owner && m_used < MB) m_used++;
      else begin
        m_owner = cur_w;
        m_used  = 1;
        m_busy  = (MB > 1);
      end
    end else if (!res && !fifo_full && req == '0) begin
      m_busy = 1'b0;
    end
    if (d_shift) begin
      check("no_overflow", 64'(fifo_q.size() < 4), 64'd1);
      fifo_q.push_back(d_data);
    end
    if (pop_en && fifo_q.size() > 0) last_pop = fifo_q.pop_front();
    #1;
    fifo_full = (fifo_q.size() >= 4);
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  // asynchronous reset pulse asserted between edges
  task automatic pulse_reset();
    #2;
    res = 1'b1;
    model_reset();
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_shift", 64'(fifo_shift_in), 64'd0);
    check("rst_data", 64'(fifo_data_in), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'(N - 1));
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    int cnt_seq[5];
    cnt_seq = '{1, 2, 1, 2, 1};
    res = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; pop_en = 1'b1;
    d_shift = 1'b0; d_data = '0; cur_w = -1; last_pop = '0;
    model_reset();
    #12;
    req = 4'b1111;
    #1;
    check("por_grant", 64'(grant), 64'd0);
    check("por_busy", 64'(busy), 64'd0);
    check("por_owner", 64'(owner), 64'd3);
    check("por_cnt", 64'(dut.burst_cnt_r), 64'd0);
    req = '0;
    @(posedge clk);
    #1;
    res = 1'b0;

    // single producer 2
    req = 4'b0100;
    req_data[2*W +: W] = 32'h0000_00A0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("t1_grant", 64'(grant), 64'h4);
      check("t1_data", 64'(fifo_data_in), 64'hA0);
      adv();
    end
    req = '0;
    step();
    sample();
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_owner", 64'(owner), 64'd2);
    adv();

    // round-robin bursts with everybody requesting
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h100 + 32'(i);
    for (int k = 0; k < 12; k++) begin
      sample();
      check("rr_seq", 64'(grant), 64'd1 << ((k / 2) % 4));
      check("rr_shift", 64'(fifo_shift_in), 64'd1);
      adv();
    end

    // early release: 1 owns, drops after one word, 3 takes over without a bubble
    pulse_reset();
    req = 4'b1010;
    sample();
    check("er_first", 64'(grant), 64'h2);
    adv();
    req = 4'b1000;
    sample();
    check("er_handover", 64'(grant), 64'h8);
    adv();
    req = '0;
    step();

    // full backpressure through producer 0
    pulse_reset();
    pop_en = 1'b0;
    fifo_q.delete();
    fifo_full = 1'b0;
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      req_data[0 +: W] = 32'(k);
      step();
    end
    check("bp_full", 64'(fifo_full), 64'd1);
    req = 4'b0011;
    req_data[0 +: W] = 32'd4;
    req_data[W +: W] = 32'd5;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("bp_grant0", 64'(grant), 64'd0);
      check("bp_cnt_hold", 64'(dut.burst_cnt_r), 64'd2);
      adv();
    end
    pop_en = 1'b1;
    step();
    check("bp_pop0", 64'(last_pop), 64'd0);
    pop_en = 1'b0;
    step();
    req = '0;
    pop_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_order", 64'(last_pop), (k < 3) ? 64'(k + 1) : 64'd5);
    end

    // exhausted owner alone is re-granted
    pulse_reset();
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      sample();
      check("ex_grant", 64'(grant), 64'h4);
      if (k > 0) check("ex_cnt", 64'(dut.burst_cnt_r), 64'(cnt_seq[k-1]));
      adv();
    end
    sample();
    check("ex_cnt", 64'(dut.burst_cnt_r), 64'(cnt_seq[4]));
    req = '0;
    adv();

    // reset mid-burst of owner 0
    pulse_reset();
    req = 4'b1111;
    step();
    check("mb_owner", 64'(owner), 64'd0);
    check("mb_busy", 64'(busy), 64'd1);
    pulse_reset();
    sample();
    check("mb_first", 64'(grant), 64'h1);
    adv();

    // random traffic with random draining
    for (int k = 0; k < 400; k++) begin
      req = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
      pop_en = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
